// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_if
// Purpose  : Command/result bundle between the E-stage control and the
//            multiply/divide unit.
// Ports    : start/op/A/B/cancel flow master -> slave;
//            busy/hi/lo flow slave -> master.
// Revision : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, A, B, cancel,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO.
//            An operation is launched from IDLE, holds busy for a fixed
//            latency per class, then commits HI and LO together on one edge.
//            MTHI/MTLO write immediately from IDLE. cancel aborts.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-low
//            bus   - md_unit_if.slave (start, op, A, B, cancel, busy, hi, lo)
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    md_unit_if.slave    bus
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW        = $clog2(c_MAX_LAT + 1);

    localparam logic [CW-1:0] c_MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] c_DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // Latencies of zero would make the down-counter meaningless.
    if (MULT_LAT < 1) begin : g_bad_mult_lat
        $error("md_unit: MULT_LAT must be >= 1");
    end
    if (DIV_LAT < 1) begin : g_bad_div_lat
        $error("md_unit: DIV_LAT must be >= 1");
    end

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_launch;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic             w_commit;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start && !bus.cancel && !bus.op[2]) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (bus.cancel || (r_cnt == c_CNT_ONE)) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: per-edge actions. cancel dominates both launch and commit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_launch = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        w_commit = 1'b0;
        if (r_state == c_IDLE) begin
            if (bus.start && !bus.cancel) begin
                w_launch = !bus.op[2];
                w_wr_hi  = (bus.op == c_OP_MTHI);
                w_wr_lo  = (bus.op == c_OP_MTLO);
            end
        end else begin
            w_commit = !bus.cancel && (r_cnt == c_CNT_ONE);
        end
    end

    // ------------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_dvs_safe;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_res_valid;

    assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) *
                      $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide works on magnitudes; the most-negative dividend maps to
    // its own bit pattern, which is the correct unsigned magnitude, so the
    // MIN / -1 case falls out as quotient MIN, remainder 0.
    assign w_neg_a    = (r_op == c_OP_DIV) && r_a[WIDTH-1];
    assign w_neg_b    = (r_op == c_OP_DIV) && r_b[WIDTH-1];
    assign w_dvd      = w_neg_a ? (~r_a + WIDTH'(1)) : r_a;
    assign w_dvs      = w_neg_b ? (~r_b + WIDTH'(1)) : r_b;
    // Divide-by-zero never commits; steer the divider away from a zero divisor.
    assign w_dvs_safe = (r_b == '0) ? WIDTH'(1) : w_dvs;
    assign w_q        = w_dvd / w_dvs_safe;
    assign w_r        = w_dvd % w_dvs_safe;
    assign w_quo      = (w_neg_a ^ w_neg_b) ? (~w_q + WIDTH'(1)) : w_q;
    assign w_rem      = w_neg_a ? (~w_r + WIDTH'(1)) : w_r;

    always_comb begin
        w_res_hi    = r_hi;
        w_res_lo    = r_lo;
        w_res_valid = 1'b0;
        case (r_op)
            c_OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_valid          = 1'b1;
            end
            c_OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_valid          = 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_res_hi    = w_rem;
                w_res_lo    = w_quo;
                w_res_valid = (r_b != '0);
            end
            default: begin
                w_res_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_launch) begin
                r_a   <= bus.A;
                r_b   <= bus.B;
                r_op  <= bus.op;
                r_cnt <= bus.op[1] ? c_DIV_CNT : c_MULT_CNT;
            end else if (r_state == c_RUN) begin
                r_cnt <= bus.cancel ? '0 : (r_cnt - c_CNT_ONE);
            end
            if (w_wr_hi) begin
                r_hi <= bus.A;
            end
            if (w_wr_lo) begin
                r_lo <= bus.A;
            end
            if (w_commit && w_res_valid) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign bus.busy = (r_state == c_RUN);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit. Expected HI/LO pairs are pushed
//            to a scoreboard queue at launch and popped when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_md_unit;

    logic clk;
    logic reset;

    md_unit_if #(.WIDTH(32)) bus  ();
    md_unit_if #(.WIDTH(32)) bus1 ();

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(3)) u_lat1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];

    // Reference model: native 64-bit arithmetic, independent of the RTL.
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] a, b,
                                          input logic [31:0] ohi, olo);
        longint sa, sb, ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        model = {ohi, olo};
        case (o)
            3'd0: model = sa * sb;
            3'd1: model = ua * ub;
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                model = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 0) begin
                q = ua / ub; r = ua % ub;
                model = {r[31:0], q[31:0]};
            end
            default: model = {ohi, olo};
        endcase
    endfunction

    // Launches one op on the main unit and counts busy cycles. Optionally
    // scrambles A/B every busy cycle and pokes an MTHI in busy cycle 2.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                          input bit scramble, input bit poke,
                          output int nbusy, output bit stable);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy  = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            nbusy++;
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
            if (scramble) begin bus.A = $urandom; bus.B = $urandom; end
            if (poke) begin
                if (nbusy == 2) begin bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hAAAA; end
                else bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_mult;
        int nb; bit st; logic [63:0] e;
        exp_q.push_back(model(3'd0, 32'hFFFFFFFE, 32'd3, bus.hi, bus.lo));
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, nb, st);
        total++; if (nb !== 5) begin bad++; $display("FAIL mult_busy: got %0d cycles want 5", nb); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL mult_hold: hi/lo changed during busy"); end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL mult_result: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    task automatic test_multu;
        int nb; bit st; logic [63:0] e;
        exp_q.push_back(model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bus.hi, bus.lo));
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, nb, st);
        total++; if (nb !== 5) begin bad++; $display("FAIL multu_busy: got %0d cycles want 5", nb); end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL multu_result: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    task automatic test_div;
        int nb; bit st; logic [63:0] e;
        exp_q.push_back(model(3'd2, 32'hFFFFFFF9, 32'd2, bus.hi, bus.lo));
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, nb, st);
        total++; if (nb !== 10) begin bad++; $display("FAIL div_busy: got %0d cycles want 10", nb); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL div_hold: hi/lo changed during busy"); end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL div_result: got %h want %h", {bus.hi, bus.lo}, e); end
        exp_q.push_back(model(3'd2, 32'h80000000, 32'hFFFFFFFF, bus.hi, bus.lo));
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, nb, st);
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL div_ovf_result: got %h want %h", {bus.hi, bus.lo}, e); end
        exp_q.push_back(model(3'd2, 32'd100, 32'hFFFFFFF9, bus.hi, bus.lo));
        run_op(3'd2, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b0, nb, st);
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL div_negb_result: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    // Start held through the completion edge must be ignored there; the
    // relaunch happens one edge later.
    task automatic test_back_to_back;
        int nb; logic [63:0] e;
        exp_q.push_back(model(3'd1, 32'd2, 32'd3, bus.hi, bus.lo));
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd2; bus.B = 32'd3;
        @(negedge clk);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            nb++;
            @(negedge clk);
        end
        total++; if (nb !== 5) begin bad++; $display("FAIL b2b_busy: got %0d cycles want 5", nb); end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL b2b_result: got %h want %h", {bus.hi, bus.lo}, e); end
        exp_q.push_back(model(3'd1, 32'd2, 32'd3, bus.hi, bus.lo));
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_relaunch: busy got %b want 1", bus.busy); end
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL b2b_relaunch_result: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    task automatic test_divzero;
        int nb; bit st; logic [63:0] e;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h1234;
        @(posedge clk); #1;
        total++; if (bus.hi !== 32'h1234) begin bad++; $display("FAIL mthi: got %h want 00001234", bus.hi); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        bus.op = 3'd5; bus.A = 32'h5678;
        @(posedge clk); #1;
        total++; if (bus.lo !== 32'h5678) begin bad++; $display("FAIL mtlo: got %h want 00005678", bus.lo); end
        @(negedge clk);
        bus.start = 1'b0;
        exp_q.push_back(model(3'd3, 32'd9, 32'd0, bus.hi, bus.lo));
        run_op(3'd3, 32'd9, 32'd0, 1'b0, 1'b1, nb, st);
        total++; if (nb !== 10) begin bad++; $display("FAIL divz_busy: got %0d cycles want 10", nb); end
        e = exp_q.pop_front();
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL divz_result: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    task automatic test_cancel;
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
        repeat (6) @(negedge clk);
        total++; if ({bus.hi, bus.lo} !== {h0, l0}) begin bad++; $display("FAIL cancel_hold: got %h want %h", {bus.hi, bus.lo}, {h0, l0}); end
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_idle_launch: busy got %b want 0", bus.busy); end
        bus.op = 3'd4; bus.A = 32'hBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        total++; if (bus.hi !== h0) begin bad++; $display("FAIL cancel_idle_mthi: got %h want %h", bus.hi, h0); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
        total++; if ({bus.hi, bus.lo} !== 64'd0) begin bad++; $display("FAIL areset_hilo: got %h want 0", {bus.hi, bus.lo}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lat1;
        int nb; logic [63:0] e;
        exp_q.push_back(model(3'd0, 32'd5, 32'hFFFFFFFA, bus1.hi, bus1.lo));
        @(negedge clk);
        bus1.start = 1'b1; bus1.op = 3'd0; bus1.A = 32'd5; bus1.B = 32'hFFFFFFFA;
        @(negedge clk);
        bus1.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus1.busy) break;
            nb++;
            @(negedge clk);
        end
        total++; if (nb !== 1) begin bad++; $display("FAIL lat1_busy: got %0d cycles want 1", nb); end
        e = exp_q.pop_front();
        total++; if ({bus1.hi, bus1.lo} !== e) begin bad++; $display("FAIL lat1_result: got %h want %h", {bus1.hi, bus1.lo}, e); end
    endtask

    initial begin
        reset = 1'b0;
        bus.start  = 1'b0; bus.cancel  = 1'b0; bus.op  = 3'd0; bus.A  = '0; bus.B  = '0;
        bus1.start = 1'b0; bus1.cancel = 1'b0; bus1.op = 3'd0; bus1.A = '0; bus1.B = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_divzero();
        test_cancel();
        test_async_reset();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS datapath. It accepts one operation per launch and holds `busy` for a configurable latency per operation class. While busy it keeps the architectural HI/LO values stable, then commits both results on one edge. The hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo instructions while `busy | start` is high. `cancel` lets the exception logic abort an in-flight operation.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_LAT`, 5: busy cycles for MULT/MULTU. Must be ≥1.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU. Must be ≥1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch/write strobe, qualified by `op`.
- `op`  in  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are no-ops.
- `A`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- `B`  in  WIDTH  rt operand (divisor / multiplier).
- `cancel`  in  1  abort the in-flight operation.
- `busy`  out  1  operation in progress.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- States: IDLE, RUN. A down-counter of width clog2(max(MULT_LAT,DIV_LAT)+1) is loaded at launch.
- IDLE with `start=1`, `cancel=0`:
  - op 0–3: latch `A`, `B`, `op`; load the counter with the matching LAT; go to RUN.
  - op 4: hi←A on that edge; stay IDLE.
  - op 5: lo←A on that edge; stay IDLE.
  - op 6/7: no effect.
- RUN:
  - The counter decrements each edge.
  - On the edge where it reaches 0, commit hi/lo and return to IDLE.
  - `start` is ignored in RUN for every op, including MTHI/MTLO.
- `cancel=1`:
  - In RUN: go to IDLE on the next edge; hi/lo keep their pre-launch values.
  - In IDLE with `start=1`: cancel wins; nothing launched or written.
- Arithmetic. Operands are latched, so later `A`/`B` changes are irrelevant.
  - MULT: {hi,lo} = signed A × signed B, full 2·WIDTH product.
  - MULTU: same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV with A = most-negative, B = −1: lo = most-negative, hi = 0.
  - DIVU: unsigned quotient/remainder.
  - DIV/DIVU with B = 0: runs full DIV_LAT, then leaves hi/lo unchanged.
- `hi`/`lo` never show partial results. They change only on MTHI/MTLO edges or completion edges.

## Timing
- Reset (`reset=0`, asynchronous): busy=0, hi=0, lo=0, state IDLE, counter 0. Asserting it mid-operation discards the operation immediately.
- Launch sampled at edge k. `busy`=1 after edge k through edge k+LAT−1.
  - At edge k+LAT: hi/lo updated, busy=0.
  - With LAT=1, busy is high for exactly one cycle.
- Back-to-back: a `start` sampled at edge k+LAT (busy was still 1 before that edge) is ignored. The earliest relaunch is edge k+LAT+1. The stall logic guarantees the instruction is re-presented.
- MTHI/MTLO: result visible on `hi`/`lo` in the cycle after the sampling edge; busy stays 0.
- `busy`, `hi`, `lo` are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then signed multiply:
  - Stimulus: reset, then MULT A=0xFFFFFFFE (−2), B=3.
  - Required: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo read 0 throughout busy.
- Unsigned multiply with operand change during busy:
  - Stimulus: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF; change A and B every cycle while busy.
  - Required: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- Signed divide and overflow case:
  - Stimulus: DIV A=−7 (0xFFFFFFF9), B=2.
  - Required: after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required: lo=0x80000000, hi=0.
- Divide by zero and ignored start:
  - Stimulus: MTHI 0x1234, MTLO 0x5678, then DIVU A=9, B=0.
  - Required: busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
  - Stimulus: MTHI 0xAAAA during that busy window.
  - Required: the MTHI is ignored.
- Cancel:
  - Stimulus: launch MULT 3×4, assert `cancel` in busy cycle 2.
  - Required: busy=0 next cycle; hi/lo keep old values.
  - Stimulus: `start` and `cancel` together in IDLE.
  - Required: no launch.
- Asynchronous reset mid-operation:
  - Stimulus: `reset`=0 mid-DIV, between clock edges.
  - Required: busy, hi, lo go to 0 without waiting for a clock edge.
  - Stimulus: parameter override MULT_LAT=1.
  - Required: busy high for exactly one cycle.
